// File: rtl/spi_regbank_burst.sv
// ============================================================================
// Module      : spi_regbank_burst
// Description : SPI target (all four modes) fronting a bank of R/W config and
//               RO status registers, with burst auto-increment and write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_regbank_burst #(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic [1:0]                      mode,
    input  logic                            spi_cs_n,
    input  logic                            spi_clk,
    input  logic                            spi_mosi,
    output logic                            spi_miso,
    output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic [NUM_CFG-1:0]              cfg_wr_stb,
    output logic                            addr_err,
    output logic                            busy
);

    localparam int CNT_W = $clog2(REG_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CFG + NUM_STATUS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                  state, state_nx;
    logic                    sclk_q, cs_q;
    logic [1:0]              mode_q;
    logic [CNT_W-1:0]        bit_cnt;
    logic [REG_WIDTH-2:0]    in_sh;
    logic [REG_WIDTH-1:0]    out_sh;
    logic                    miso_q;
    logic                    rw;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [REG_WIDTH-1:0]    cfg [NUM_CFG];

    logic                    rise, fall, cs_fall, edge_ok, sample_ev, shift_ev;
    logic                    cmd_done, frame_done;
    logic [7:0]              cmd_byte;
    logic [REG_WIDTH-1:0]    frame_data, rd_word;
    logic [ADDR_WIDTH-1:0]   addr_inc, load_addr;

    assign rise       = spi_clk & ~sclk_q;
    assign fall       = ~spi_clk & sclk_q;
    assign cs_fall    = cs_q & ~spi_cs_n;
    // An SPI clock edge coincident with the CS fall is a setup violation, not a sample.
    assign edge_ok    = ena & ~spi_cs_n & ~cs_fall;
    assign sample_ev  = edge_ok & ((mode_q[1] == mode_q[0]) ? rise : fall);
    assign shift_ev   = edge_ok & ((mode_q[1] == mode_q[0]) ? fall : rise);
    assign cmd_byte   = {in_sh[6:0], spi_mosi};
    assign frame_data = {in_sh, spi_mosi};
    assign addr_inc   = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    assign load_addr  = (state == CMD) ? cmd_byte[ADDR_WIDTH-1:0] : addr_inc;
    assign busy       = (state != IDLE);
    assign spi_miso   = (state == DATA) & ~spi_cs_n & miso_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        cmd_done   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: if (ena && cs_fall) state_nx = CMD;
            CMD: begin
                if (ena && spi_cs_n) state_nx = IDLE;
                else if (sample_ev && bit_cnt == CNT_W'(7)) begin
                    cmd_done = 1'b1;
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (ena && spi_cs_n) state_nx = IDLE;
                else if (sample_ev && bit_cnt == CNT_W'(REG_WIDTH - 1)) frame_done = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Readback word for whichever address is about to be shifted out.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < NUM_CFG; r++)
            if (load_addr == ADDR_WIDTH'(r)) rd_word = cfg[r];
        for (int s = 0; s < NUM_STATUS; s++)
            if (load_addr == ADDR_WIDTH'(NUM_CFG + s)) rd_word = status_regs[s*REG_WIDTH +: REG_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            mode_q     <= 2'b00;
            bit_cnt    <= '0;
            in_sh      <= '0;
            out_sh     <= '0;
            miso_q     <= 1'b0;
            rw         <= 1'b0;
            addr       <= '0;
            cfg_wr_stb <= '0;
            addr_err   <= 1'b0;
            for (int r = 0; r < NUM_CFG; r++) cfg[r] <= '0;
        end else begin
            sclk_q     <= spi_clk;
            cs_q       <= spi_cs_n;
            cfg_wr_stb <= '0;
            addr_err   <= 1'b0;
            if (state == IDLE && state_nx == CMD) begin
                mode_q  <= mode;
                bit_cnt <= '0;
                miso_q  <= 1'b0;
            end
            if (state != IDLE && sample_ev) begin
                in_sh <= frame_data[REG_WIDTH-2:0];
                if (cmd_done || frame_done) bit_cnt <= '0;
                else                        bit_cnt <= bit_cnt + 1'b1;
            end
            if (cmd_done) begin
                rw   <= cmd_byte[7];
                addr <= cmd_byte[ADDR_WIDTH-1:0];
            end
            if (frame_done) begin
                addr <= addr_inc;
                if (rw) begin
                    if (addr < ADDR_WIDTH'(NUM_CFG)) begin
                        for (int r = 0; r < NUM_CFG; r++)
                            if (addr == ADDR_WIDTH'(r)) begin
                                cfg[r]        <= frame_data;
                                cfg_wr_stb[r] <= 1'b1;
                            end
                    end else begin
                        addr_err <= 1'b1;
                    end
                end
            end
            // cpha=0 presents the MSB at load and must skip the trailing edge that follows it.
            if (cmd_done || frame_done) begin
                if (mode_q[0]) begin
                    out_sh <= rd_word;
                end else begin
                    miso_q <= rd_word[REG_WIDTH-1];
                    out_sh <= {rd_word[REG_WIDTH-2:0], 1'b0};
                end
            end else if (state == DATA && shift_ev && (mode_q[0] || bit_cnt != '0)) begin
                miso_q <= out_sh[REG_WIDTH-1];
                out_sh <= {out_sh[REG_WIDTH-2:0], 1'b0};
            end
        end
    end

    for (genvar r = 0; r < NUM_CFG; r++) begin : g_pack
        assign config_regs[r*REG_WIDTH +: REG_WIDTH] = cfg[r];
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_regbank_burst.sv
// ============================================================================
// Module      : tb_spi_regbank_burst
// Description : Self-checking bench: SPI controller model plus register-bank reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_regbank_burst;

    localparam int NC = 8, NS = 8, W = 8, AW = 7, HALF = 4;

    logic clk = 1'b0;
    logic rst, ena, spi_cs_n, spi_clk, spi_mosi, spi_miso, addr_err, busy;
    logic [1:0]      mode;
    logic [NC*W-1:0] config_regs;
    logic [NS*W-1:0] status_regs;
    logic [NC-1:0]   cfg_wr_stb;

    always #5 clk = ~clk;

    spi_regbank_burst #(.NUM_CFG(NC), .NUM_STATUS(NS), .REG_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .spi_cs_n(spi_cs_n),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .config_regs(config_regs), .status_regs(status_regs),
        .cfg_wr_stb(cfg_wr_stb), .addr_err(addr_err), .busy(busy)
    );

    int n_checks = 0, n_fail = 0;
    logic [7:0] tx_buf[16], rx_buf[16], exp_rx[16], cfg_m[NC], st_m[NS];
    int stb_tot[NC] = '{default: 0};
    int err_tot = 0;
    int stb_base[NC], err_base, exp_stb[NC], exp_err;

    // Pulse monitor: every clock a strobe is high counts as one write event.
    always @(negedge clk) begin
        for (int r = 0; r < NC; r++) if (cfg_wr_stb[r] === 1'b1) stb_tot[r]++;
        if (addr_err === 1'b1) err_tot++;
    end

    function automatic logic [7:0] word_of(input int a);
        if (a < NC) return cfg_m[a];
        if (a < NC + NS) return st_m[a-NC];
        return 8'h00;
    endfunction

    task automatic new_status();
        for (int s = 0; s < NS; s++) begin
            st_m[s] = 8'($urandom);
            status_regs[s*W +: W] = st_m[s];
        end
    endtask

    task automatic prep(input bit rw, input int a, input int nfr);
        tx_buf[0] = {rw, a[6:0]};
        for (int f = 1; f <= nfr; f++) tx_buf[f] = 8'($urandom);
    endtask

    // Reference: address walks with wrap at the end of the bank; writes echo old value.
    task automatic model(input int nfr);
        int a;
        a = int'(tx_buf[0][6:0]);
        exp_rx[0] = 8'h00;
        exp_err = 0;
        for (int r = 0; r < NC; r++) begin exp_stb[r] = 0; stb_base[r] = stb_tot[r]; end
        err_base = err_tot;
        for (int f = 1; f <= nfr; f++) begin
            exp_rx[f] = word_of(a);
            if (tx_buf[0][7]) begin
                if (a < NC) begin cfg_m[a] = tx_buf[f]; exp_stb[a]++; end
                else exp_err++;
            end
            a = (a == NC + NS - 1) ? 0 : (a + 1) % 128;
        end
    endtask

    task automatic spi_xfer(input logic [1:0] m, input int nbits, input bit raise_cs);
        logic c, p;
        c = m[1];
        p = m[0];
        @(negedge clk);
        mode = m;
        spi_clk = c;
        for (int f = 0; f < 16; f++) rx_buf[f] = 8'h00;
        repeat (3) @(negedge clk);
        spi_cs_n = 1'b0;
        if (!p) spi_mosi = tx_buf[0][7];
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (p) spi_mosi = tx_buf[i/8][7-(i%8)];
            spi_clk = ~c;
            if (!p) rx_buf[i/8][7-(i%8)] = spi_miso;
            repeat (HALF) @(negedge clk);
            spi_clk = c;
            if (p) rx_buf[i/8][7-(i%8)] = spi_miso;
            if (!p && i + 1 < nbits) spi_mosi = tx_buf[(i+1)/8][7-((i+1)%8)];
            repeat (HALF) @(negedge clk);
        end
        if (raise_cs) begin
            spi_cs_n = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_checks += 5;
        if (config_regs !== '0) begin n_fail++; $display("FAIL reset config_regs: got %h want 0", config_regs); end
        if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset spi_miso: got %b want 0", spi_miso); end
        if (cfg_wr_stb !== '0) begin n_fail++; $display("FAIL reset cfg_wr_stb: got %h want 0", cfg_wr_stb); end
        if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset addr_err: got %b want 0", addr_err); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    endtask

    task automatic test_mode0_write();
        prep(1'b1, 2, 1);
        tx_buf[1] = 8'hA5;
        model(1);
        spi_xfer(2'd0, 16, 1'b1);
        n_checks += 2;
        if (config_regs[2*W +: W] !== 8'hA5) begin n_fail++; $display("FAIL m0 reg2: got %h want a5", config_regs[2*W +: W]); end
        if (rx_buf[1] !== exp_rx[1]) begin n_fail++; $display("FAIL m0 echo: got %h want %h", rx_buf[1], exp_rx[1]); end
        for (int r = 0; r < NC; r++) begin
            n_checks += 2;
            if (config_regs[r*W +: W] !== cfg_m[r]) begin n_fail++; $display("FAIL m0 reg%0d: got %h want %h", r, config_regs[r*W +: W], cfg_m[r]); end
            if (stb_tot[r] - stb_base[r] != exp_stb[r]) begin n_fail++; $display("FAIL m0 stb%0d: got %0d want %0d", r, stb_tot[r] - stb_base[r], exp_stb[r]); end
        end
    endtask

    task automatic test_mode3_burst();
        prep(1'b1, 6, 3);
        tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
        model(3);
        spi_xfer(2'd3, 32, 1'b1);
        n_checks += 4;
        if (config_regs[6*W +: W] !== 8'h11) begin n_fail++; $display("FAIL m3 reg6: got %h want 11", config_regs[6*W +: W]); end
        if (config_regs[7*W +: W] !== 8'h22) begin n_fail++; $display("FAIL m3 reg7: got %h want 22", config_regs[7*W +: W]); end
        if (err_tot - err_base != 1) begin n_fail++; $display("FAIL m3 addr_err: got %0d pulses want 1", err_tot - err_base); end
        if (stb_tot[6] - stb_base[6] != 1 || stb_tot[7] - stb_base[7] != 1)
            begin n_fail++; $display("FAIL m3 stb: got %0d,%0d want 1,1", stb_tot[6] - stb_base[6], stb_tot[7] - stb_base[7]); end
        for (int f = 1; f <= 3; f++) begin
            n_checks++;
            if (rx_buf[f] !== exp_rx[f]) begin n_fail++; $display("FAIL m3 echo%0d: got %h want %h", f, rx_buf[f], exp_rx[f]); end
        end
    endtask

    task automatic test_read_modes12();
        for (int k = 1; k <= 2; k++) begin
            new_status();
            st_m[1] = 8'h5A;
            status_regs[1*W +: W] = 8'h5A;
            prep(1'b0, NC + 1, 2);
            model(2);
            spi_xfer(2'(k), 24, 1'b1);
            n_checks += 3;
            if (rx_buf[1] !== 8'h5A) begin n_fail++; $display("FAIL rd mode%0d st1: got %h want 5a", k, rx_buf[1]); end
            if (rx_buf[2] !== st_m[2]) begin n_fail++; $display("FAIL rd mode%0d st2: got %h want %h", k, rx_buf[2], st_m[2]); end
            if (err_tot != err_base) begin n_fail++; $display("FAIL rd mode%0d addr_err: got %0d want 0", k, err_tot - err_base); end
        end
    endtask

    task automatic test_wrap();
        new_status();
        prep(1'b0, 15, 2);
        model(2);
        spi_xfer(2'd0, 24, 1'b1);
        n_checks += 2;
        if (rx_buf[1] !== st_m[7]) begin n_fail++; $display("FAIL wrap st7: got %h want %h", rx_buf[1], st_m[7]); end
        if (rx_buf[2] !== cfg_m[0]) begin n_fail++; $display("FAIL wrap cfg0: got %h want %h", rx_buf[2], cfg_m[0]); end
    endtask

    task automatic test_partial();
        prep(1'b1, 3, 1);
        model(0);
        spi_xfer(2'd0, 13, 1'b1);
        n_checks += 2;
        if (config_regs[3*W +: W] !== cfg_m[3]) begin n_fail++; $display("FAIL partial reg3: got %h want %h", config_regs[3*W +: W], cfg_m[3]); end
        if (stb_tot[3] != stb_base[3] || err_tot != err_base) begin n_fail++; $display("FAIL partial pulses: stb %0d err %0d want 0 0", stb_tot[3] - stb_base[3], err_tot - err_base); end
        prep(1'b1, 3, 1);
        model(1);
        spi_xfer(2'd0, 16, 1'b1);
        n_checks += 2;
        if (config_regs[3*W +: W] !== cfg_m[3]) begin n_fail++; $display("FAIL partial next reg3: got %h want %h", config_regs[3*W +: W], cfg_m[3]); end
        if (stb_tot[3] - stb_base[3] != 1) begin n_fail++; $display("FAIL partial next stb3: got %0d want 1", stb_tot[3] - stb_base[3]); end
    endtask

    task automatic test_mid_reset();
        prep(1'b1, 4, 3);
        spi_xfer(2'd2, 19, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst busy: got %b want 1", busy); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (config_regs !== '0) begin n_fail++; $display("FAIL midrst config: got %h want 0", config_regs); end
        if (cfg_wr_stb !== '0 || addr_err !== 1'b0) begin n_fail++; $display("FAIL midrst pulses: stb %h err %b want 0", cfg_wr_stb, addr_err); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy: got %b want 0", busy); end
        if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL midrst miso: got %b want 0", spi_miso); end
        spi_cs_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < NC; r++) cfg_m[r] = 8'h00;
        repeat (3) @(negedge clk);
        prep(1'b1, 5, 1);
        model(1);
        spi_xfer(2'd1, 16, 1'b1);
        n_checks += 2;
        if (config_regs[5*W +: W] !== cfg_m[5]) begin n_fail++; $display("FAIL midrst fresh reg5: got %h want %h", config_regs[5*W +: W], cfg_m[5]); end
        if (stb_tot[5] - stb_base[5] != 1) begin n_fail++; $display("FAIL midrst fresh stb5: got %0d want 1", stb_tot[5] - stb_base[5]); end
    endtask

    task automatic test_random();
        int nfr, a;
        for (int t = 0; t < 25; t++) begin
            new_status();
            nfr = $urandom_range(1, 4);
            a = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 127) : $urandom_range(0, NC + NS - 1);
            prep(1'($urandom), a, nfr);
            model(nfr);
            spi_xfer(2'($urandom), 8 * (nfr + 1), 1'b1);
            for (int f = 0; f <= nfr; f++) begin
                n_checks++;
                if (rx_buf[f] !== exp_rx[f]) begin n_fail++; $display("FAIL rand t%0d rx%0d: got %h want %h", t, f, rx_buf[f], exp_rx[f]); end
            end
            for (int r = 0; r < NC; r++) begin
                n_checks += 2;
                if (config_regs[r*W +: W] !== cfg_m[r]) begin n_fail++; $display("FAIL rand t%0d reg%0d: got %h want %h", t, r, config_regs[r*W +: W], cfg_m[r]); end
                if (stb_tot[r] - stb_base[r] != exp_stb[r]) begin n_fail++; $display("FAIL rand t%0d stb%0d: got %0d want %0d", t, r, stb_tot[r] - stb_base[r], exp_stb[r]); end
            end
            n_checks++;
            if (err_tot - err_base != exp_err) begin n_fail++; $display("FAIL rand t%0d addr_err: got %0d want %0d", t, err_tot - err_base, exp_err); end
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; mode = 2'd0;
        spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        status_regs = '0;
        for (int r = 0; r < NC; r++) cfg_m[r] = 8'h00;
        for (int s = 0; s < NS; s++) st_m[s] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_mode0_write();
        test_mode3_burst();
        test_read_modes12();
        test_wrap();
        test_partial();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
